// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and encoder helpers for the keypad scanner
// Contents: scanner state enum, matrix dimensions, row-drive reset value,
//           one-hot row index encoder and lowest-set-column encoder.
package keypad_pkg;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int KEY_CODE_W = 4;

    localparam logic [ROWS-1:0] ROW_SEL_RESET = 4'b0001;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_e;

    // row_sel is always one-hot, so a plain OR encoder is sufficient.
    function automatic logic [1:0] onehot_to_idx(input logic [ROWS-1:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

    // Several closed columns in one row resolve to the lowest column.
    function automatic logic [1:0] lowest_col_idx(input logic [COLS-1:0] cols);
        logic [1:0] idx;
        if (cols[0])      idx = 2'd0;
        else if (cols[1]) idx = 2'd1;
        else if (cols[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// rtl/keypad_tick_gen.sv - clock-enable divider producing one scan tick every DIV clk cycles
// Ports: clk  - system clock
//        rst  - asynchronous active-low reset (counter returns to 0)
//        tick - single-cycle enable, high while the counter equals DIV-1
module keypad_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and single key events
// Ports: clk       - system clock
//        rst       - asynchronous active-low reset
//        col_in    - column lines, active-high, asynchronous to clk
//        row_sel   - one-hot active-high row drive
//        key_code  - {row_idx, col_idx} of the last accepted key
//        key_valid - one-cycle pulse per accepted key event
//        key_held  - high while the accepted key remains pressed
// Optional macro KEYPAD_AUTOREPEAT_EN: re-pulses key_valid every REPEAT_TICKS
// ticks while the same column pattern stays held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int REPEAT_TICKS   = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLS-1:0]       col_in,
    output logic [ROWS-1:0]       row_sel,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int              DW        = $clog2(DEBOUNCE_TICKS + 2);
    localparam logic [DW-1:0]   DEB_LIMIT = DW'(DEBOUNCE_TICKS);

    logic tick;

    keypad_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e                  state_q, state_d;
    logic [COLS-1:0]         col_meta_q, col_meta_d;
    logic [COLS-1:0]         col_s_q, col_s_d;
    logic [ROWS-1:0]         row_sel_q, row_sel_d;
    logic [1:0]              row_idx_q, row_idx_d;
    logic [1:0]              col_idx_q, col_idx_d;
    logic [COLS-1:0]         pat_q, pat_d;
    logic [DW-1:0]           deb_cnt_q, deb_cnt_d;
    logic [KEY_CODE_W-1:0]   key_code_q, key_code_d;
    logic                    key_valid_q, key_valid_d;
    logic                    key_held_q, key_held_d;

    logic [DW-1:0] deb_inc;
    logic          col_idle;
    logic          col_match;
    logic          accept;
    logic          release_done;
    logic          repeat_fire;

    assign deb_inc   = deb_cnt_q + DW'(1);
    assign col_idle  = (col_s_q == '0);
    assign col_match = (col_s_q == pat_q);

    // The detection tick already counts as the first stable sample, so the
    // acceptance test can only fire from DEBOUNCE (never on the detection tick).
    assign accept       = tick && (state_q == DEBOUNCE) && col_match && (deb_inc >= DEB_LIMIT);
    assign release_done = tick && (state_q == PRESSED) && col_idle && (deb_inc >= DEB_LIMIT);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [RW-1:0] rep_inc;

    assign rep_inc = rep_cnt_q + RW'(1);

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        repeat_fire = 1'b0;
        if (accept) begin
            rep_cnt_d = '0;
        end else if (tick && (state_q == PRESSED)) begin
            if (!col_match) begin
                rep_cnt_d = '0;
            end else if (rep_inc == RW'(REPEAT_TICKS)) begin
                rep_cnt_d   = '0;
                repeat_fire = 1'b1;
            end else begin
                rep_cnt_d = rep_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rep_cnt_q <= '0;
        else      rep_cnt_q <= rep_cnt_d;
    end
`else
    logic unused_repeat_ticks;
    assign unused_repeat_ticks = ^REPEAT_TICKS;
    assign repeat_fire         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SCAN;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                SCAN:     if (!col_idle) state_d = DEBOUNCE;
                DEBOUNCE: begin
                    if (!col_match)  state_d = SCAN;
                    else if (accept) state_d = PRESSED;
                end
                PRESSED:  if (release_done) state_d = SCAN;
                default:  state_d = SCAN;
            endcase
        end
    end

    // Datapath / output logic.
    always_comb begin
        col_meta_d  = col_in;
        col_s_d     = col_meta_q;
        row_sel_d   = row_sel_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        pat_d       = pat_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = repeat_fire;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (col_idle) begin
                        row_sel_d = {row_sel_q[ROWS-2:0], row_sel_q[ROWS-1]};
                    end else begin
                        row_idx_d = onehot_to_idx(row_sel_q);
                        col_idx_d = lowest_col_idx(col_s_q);
                        pat_d     = col_s_q;
                        deb_cnt_d = DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (accept) begin
                        key_code_d  = {row_idx_q, col_idx_q};
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        deb_cnt_d   = '0;
                    end else if (col_match) begin
                        deb_cnt_d = deb_inc;
                    end
                end
                PRESSED: begin
                    // deb_cnt doubles as the release counter here.
                    if (release_done) begin
                        key_held_d = 1'b0;
                        deb_cnt_d  = '0;
                    end else if (col_idle) begin
                        deb_cnt_d = deb_inc;
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta_q  <= '0;
            col_s_q     <= '0;
            row_sel_q   <= ROW_SEL_RESET;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            pat_q       <= '0;
            deb_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            col_meta_q  <= col_meta_d;
            col_s_q     <= col_s_d;
            row_sel_q   <= row_sel_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            pat_q       <= pat_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign row_sel   = row_sel_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a modelled key matrix
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_in;
    logic [3:0] row_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] keys [4];

    int         tests_run = 0;
    int         tests_failed = 0;
    int         pulse_cnt = 0;
    logic [3:0] exp_q [$];

    typedef struct {
        int         row;
        logic [3:0] cols;
        logic [3:0] extra;
        bit         bounce;
        int         hold;
        logic [3:0] code;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    // Key matrix: a closed key connects its row drive to its column line.
    always_comb begin
        col_in = 4'b0000;
        for (int r = 0; r < 4; r++)
            if (row_sel[r]) col_in = col_in | keys[r];
    end

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_TICKS (DEB),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .col_in    (col_in),
        .row_sel   (row_sel),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every key_valid pulse consumes one expected code.
    always @(negedge clk) begin
        if (rst_n && key_valid) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_key_valid: got pulse with code %0h expected none", key_code);
            end else begin
                check("event_key_code", key_code, exp_q.pop_front());
            end
        end
    end

    task automatic wait_held(input logic lvl, input int budget, output int n);
        n = 0;
        while (key_held !== lvl && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_row(input logic [3:0] want, input int budget);
        int n;
        n = 0;
        while (row_sel !== want && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_row_reached", row_sel, want);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_row_sel"}, row_sel, 4'b0001);
        check({tag, "_key_code"}, key_code, 4'h0);
        check({tag, "_key_valid"}, key_valid, 1'b0);
        check({tag, "_key_held"}, key_held, 1'b0);
    endtask

    initial begin
        logic [3:0] exp_row;
        logic [3:0] oh;
        int         n;
        int         reps;
        int         start_pulses;

        for (int r = 0; r < 4; r++) keys[r] = 4'b0000;

        vecs[0] = '{row: 2, cols: 4'b0010, extra: 4'b0000, bounce: 1'b0, hold: 20, code: 4'b1001};
        vecs[1] = '{row: 0, cols: 4'b1000, extra: 4'b0000, bounce: 1'b1, hold: 8,  code: 4'b0011};
        vecs[2] = '{row: 3, cols: 4'b0101, extra: 4'b0010, bounce: 1'b0, hold: 10, code: 4'b1100};
        vecs[3] = '{row: 1, cols: 4'b0001, extra: 4'b0000, bounce: 1'b0, hold: 28, code: 4'b0100};

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Idle scanning: one rotation per SCAN_DIV clocks after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        exp_row = 4'b0001;
        repeat (SCAN_DIV - 1) @(posedge clk);
        #1;
        check("row_before_first_tick", row_sel, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            exp_row = {exp_row[2:0], exp_row[3]};
            check("idle_row_rotate", row_sel, exp_row);
            if (i != 7) repeat (SCAN_DIV - 1) @(posedge clk);
        end
        check("idle_no_pulse", pulse_cnt, 0);
        check("idle_held_low", key_held, 1'b0);

        for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << vecs[i].row;
            start_pulses = pulse_cnt;
            reps = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (vecs[i].extra == 4'b0000) reps = vecs[i].hold / REP;
`endif
            if (vecs[i].bounce) begin
                for (int b = 0; b < 4; b++) begin
                    keys[vecs[i].row] = (b % 2 == 0) ? vecs[i].cols : 4'b0000;
                    repeat (SCAN_DIV) @(posedge clk);
                    #1;
                end
                check("bounce_no_pulse", pulse_cnt - start_pulses, 0);
                check("bounce_held_low", key_held, 1'b0);
            end

            for (int k = 0; k <= reps; k++) exp_q.push_back(vecs[i].code);
            keys[vecs[i].row] = vecs[i].cols;
            wait_held(1'b1, 200, n);
            check("press_accepted", key_held, 1'b1);
            check("row_frozen_at_accept", row_sel, oh);
            check("key_code_latched", key_code, vecs[i].code);

            if (vecs[i].extra != 4'b0000) begin
                repeat (2 * SCAN_DIV) @(posedge clk);
                #1;
                keys[vecs[i].row] = vecs[i].cols | vecs[i].extra;
                repeat ((vecs[i].hold - 2) * SCAN_DIV) @(posedge clk);
            end else begin
                repeat (vecs[i].hold * SCAN_DIV) @(posedge clk);
            end
            #1;
            check("row_frozen_while_held", row_sel, oh);
            check("held_while_pressed", key_held, 1'b1);
            check("code_unchanged_while_held", key_code, vecs[i].code);

            keys[vecs[i].row] = 4'b0000;
            wait_held(1'b0, 100, n);
            check("release_held_low", key_held, 1'b0);
            check("release_debounce_window", (n >= 11 && n <= 14), 1'b1);
            repeat (SCAN_DIV) @(posedge clk);
            #1;
            check("scan_resumes", row_sel, {oh[2:0], oh[3]});
            check("pulses_per_press", pulse_cnt - start_pulses, reps + 1);
            check("scoreboard_drained", exp_q.size(), 0);
        end

        // Reset in DEBOUNCE: row2/col1 detected when row 0100 is sampled.
        wait_row(4'b0001, 100);
        keys[2] = 4'b0010;
        wait_row(4'b0100, 100);
        repeat (6) @(posedge clk);
        #2;
        check("debounce_not_yet_held", key_held, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_in_debounce");
        @(negedge clk);
        rst_n = 1'b1;
        start_pulses = pulse_cnt;
        exp_q.push_back(4'b1001);
        wait_held(1'b1, 200, n);
        check("reaccept_after_debounce_reset", key_held, 1'b1);
        check("reaccept_code_1", key_code, 4'b1001);

        // Reset in PRESSED, key still down.
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_in_pressed");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'b1001);
        wait_held(1'b1, 200, n);
        check("reaccept_after_pressed_reset", key_held, 1'b1);
        check("reaccept_code_2", key_code, 4'b1001);
        keys[2] = 4'b0000;
        wait_held(1'b0, 100, n);
        check("final_release", key_held, 1'b0);
        check("reset_seq_pulses", pulse_cnt - start_pulses, 2);
        check("final_scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
